alu_mdu: RTL and testbench

Parametrised next-generation execution unit for the MIPS datapath. It merges the single-cycle ALU and shifter with an iterative unsigned multiply/divide unit and architectural HI/LO registers. It sits in the EX stage and replaces the combinational ALU/shifter pair. A valid/ready handshake lets the pipeline stall while MULTU or DIVU iterate.

---
 rtl/alu_mdu_pkg.sv | 36 +++
 rtl/alu_mdu_iter.sv | 102 ++++++++++
 rtl/alu_mdu.sv | 125 ++++++++++++
 tb/tb_alu_mdu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared constants and types for the alu_mdu execution unit.
// ALU_MDU_DIVU_EN compiles in the divider and the DIV state.
package alu_mdu_pkg;

    localparam logic [5:0] F_SLL   = 6'd0;
    localparam logic [5:0] F_SRL   = 6'd2;
    localparam logic [5:0] F_SRA   = 6'd3;
    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIVU  = 6'd27;
    localparam logic [5:0] F_ADD   = 6'd32;
    localparam logic [5:0] F_SUB   = 6'd34;
    localparam logic [5:0] F_AND   = 6'd36;
    localparam logic [5:0] F_OR    = 6'd37;
    localparam logic [5:0] F_SLT   = 6'd42;

`ifdef ALU_MDU_DIVU_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } mdu_state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1
    } mdu_state_t;
`endif

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mdu_mode_t;

endpackage

// File: rtl/alu_mdu_iter.sv
// mdu_iter: one-bit-per-cycle unsigned multiply (shift-add) / divide (restoring).
// The divide datapath exists only when ALU_MDU_DIVU_EN is defined.
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  mdu_mode_t        mode,
    input  logic             busy,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             cnt_done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic [WIDTH-1:0] w_b;
    logic [CW-1:0]    cnt;
    mdu_mode_t        w_mode;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;
    logic [WIDTH-1:0] n_hi;
    logic [WIDTH-1:0] n_lo;

    // Multiply: w_lo holds the remaining multiplier bits, low product bits shift in from the top.
    always_comb begin
        sum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
        mul_hi = sum[WIDTH:1];
        mul_lo = {sum[0], w_lo[WIDTH-1:1]};
    end

`ifdef ALU_MDU_DIVU_EN
    logic [WIDTH:0]   sh_rem;
    logic [WIDTH-1:0] trial;
    logic             fits;
    logic [WIDTH-1:0] div_hi;
    logic [WIDTH-1:0] div_lo;

    // Divide: w_hi is the partial remainder, w_lo shifts dividend out and quotient in.
    // A zero divisor always fits, which yields quotient all-ones and remainder = dividend.
    always_comb begin
        sh_rem = {w_hi, w_lo[WIDTH-1]};
        fits   = (sh_rem >= {1'b0, w_b});
        trial  = sh_rem[WIDTH-1:0] - w_b;
        div_hi = fits ? trial : sh_rem[WIDTH-1:0];
        div_lo = {w_lo[WIDTH-2:0], fits};
    end

    always_comb begin
        if (w_mode == MODE_DIV) begin
            n_hi = div_hi;
            n_lo = div_lo;
        end else begin
            n_hi = mul_hi;
            n_lo = mul_lo;
        end
    end
`else
    always_comb begin
        n_hi = w_hi;
        n_lo = w_lo;
        if (w_mode == MODE_MUL) begin
            n_hi = mul_hi;
            n_lo = mul_lo;
        end
    end
`endif

    assign cnt_done = (cnt == '0);
    assign res_hi   = n_hi;
    assign res_lo   = n_lo;

    // Multiplication commutes, so both modes latch dataA into w_lo and dataB into w_b.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_hi   <= '0;
            w_lo   <= '0;
            w_b    <= '0;
            cnt    <= '0;
            w_mode <= MODE_MUL;
        end else if (start) begin
            w_hi   <= '0;
            w_lo   <= op_a;
            w_b    <= op_b;
            cnt    <= CW'(WIDTH - 1);
            w_mode <= mode;
        end else if (busy) begin
            w_hi <= n_hi;
            w_lo <= n_lo;
            cnt  <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU/shifter plus iterative MULTU/DIVU with HI/LO and valid/ready.
// ALU_MDU_DIVU_EN enables DIVU; otherwise funct 27 is reported illegal.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataOut,
    output logic             zero,
    output logic             illegal,
    output mdu_state_t       dbg_state
);

    // Handshake: an operation transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE, and out_valid pulses once per accepted operation.

    mdu_state_t       state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic             accept;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             mdu_go;
    mdu_mode_t        mdu_mode;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    assign in_ready  = (state == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign dbg_state = state;

    always_comb begin
        alu_res  = '0;
        alu_ill  = 1'b0;
        mdu_go   = 1'b0;
        mdu_mode = MODE_MUL;
        case (funct)
            F_AND:   alu_res = dataA & dataB;
            F_OR:    alu_res = dataA | dataB;
            F_ADD:   alu_res = dataA + dataB;
            F_SUB:   alu_res = dataA - dataB;
            F_SLT:   alu_res[0] = ($signed(dataA) < $signed(dataB));
            F_SLL:   alu_res = dataB << shamt;
            F_SRL:   alu_res = dataB >> shamt;
            F_SRA:   alu_res = $unsigned($signed(dataB) >>> shamt);
            F_MFHI:  alu_res = hi;
            F_MFLO:  alu_res = lo;
            F_MULTU: mdu_go = 1'b1;
`ifdef ALU_MDU_DIVU_EN
            F_DIVU: begin
                mdu_go   = 1'b1;
                mdu_mode = MODE_DIV;
            end
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .reset    (reset),
        .start    (accept && mdu_go),
        .mode     (mdu_mode),
        .busy     (state != S_IDLE),
        .op_a     (dataA),
        .op_b     (dataB),
        .cnt_done (iter_done),
        .res_hi   (iter_hi),
        .res_lo   (iter_lo)
    );

    // Busy states finish on the edge where the counter already reads zero: that is the last step.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            hi        <= '0;
            lo        <= '0;
            out_valid <= 1'b0;
            dataOut   <= '0;
            zero      <= 1'b1;
            illegal   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == S_IDLE) begin
                if (accept) begin
                    if (mdu_go) begin
`ifdef ALU_MDU_DIVU_EN
                        state <= (mdu_mode == MODE_DIV) ? S_DIV : S_MUL;
`else
                        state <= S_MUL;
`endif
                    end else begin
                        out_valid <= 1'b1;
                        dataOut   <= alu_res;
                        zero      <= (alu_res == '0);
                        illegal   <= alu_ill;
                    end
                end
            end else if (iter_done) begin
                state     <= S_IDLE;
                hi        <= iter_hi;
                lo        <= iter_lo;
                out_valid <= 1'b1;
                dataOut   <= iter_lo;
                zero      <= (iter_lo == '0);
                illegal   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32) with a scoreboard of expected {illegal, dataOut}.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [5:0]    funct = 6'd0;
    logic [W-1:0]  dataA = '0;
    logic [W-1:0]  dataB = '0;
    logic [SW-1:0] shamt = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  dataOut;
    logic          zero;
    logic          illegal;
    logic [1:0]    dbg_state;

    int           errors = 0;
    int           checks = 0;
    logic [W:0]   exp_q[$];
    logic [W:0]   mon_e;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_mdu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .dataA     (dataA),
        .dataB     (dataB),
        .shamt     (shamt),
        .out_valid (out_valid),
        .dataOut   (dataOut),
        .zero      (zero),
        .illegal   (illegal),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got data=%h illegal=%b, required no output", dataOut, illegal);
            end else begin
                mon_e = exp_q.pop_front();
                checks++;
                if ({illegal, dataOut} !== mon_e) begin
                    errors++;
                    $display("FAIL sb_result: got illegal=%b data=%h, required illegal=%b data=%h",
                             illegal, dataOut, mon_e[W], mon_e[W-1:0]);
                end
                checks++;
                if (zero !== (mon_e[W-1:0] == '0)) begin
                    errors++;
                    $display("FAIL sb_zero: got %b for data=%h", zero, mon_e[W-1:0]);
                end
            end
        end
    end

    task automatic send(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [SW-1:0] sh);
        int          n;
        logic [63:0] p;
        logic [63:0] wide;
        logic [W-1:0] r;
        logic        ill;
        in_valid = 1'b1;
        funct = f;
        dataA = a;
        dataB = b;
        shamt = sh;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        ill = 1'b0;
        r = '0;
        case (f)
            F_AND: r = a & b;
            F_OR:  r = a | b;
            F_ADD: r = a + b;
            F_SUB: r = a - b;
            F_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F_SLL: r = b << sh;
            F_SRL: r = b >> sh;
            F_SRA: begin
                wide = {{W{b[W-1]}}, b};
                wide = wide >> sh;
                r = wide[W-1:0];
            end
            F_MFHI: r = m_hi;
            F_MFLO: r = m_lo;
            F_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
                r = m_lo;
            end
`ifdef ALU_MDU_DIVU_EN
            F_DIVU: begin
                if (b == '0) begin
                    m_hi = a;
                    m_lo = '1;
                end else begin
                    m_hi = a % b;
                    m_lo = a / b;
                end
                r = m_lo;
            end
`endif
            default: ill = 1'b1;
        endcase
        @(posedge clk);
        exp_q.push_back({ill, r});
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || !in_ready) begin
            errors++;
            $display("FAIL drain: pending=%0d in_ready=%b, required 0 and 1", exp_q.size(), in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        checks++; if (dataOut !== '0)     begin errors++; $display("FAIL rst_dataOut: got %h, required 0", dataOut); end
        checks++; if (zero !== 1'b1)      begin errors++; $display("FAIL rst_zero: got %b, required 1", zero); end
        checks++; if (illegal !== 1'b0)   begin errors++; $display("FAIL rst_illegal: got %b, required 0", illegal); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d, required 0", dbg_state); end
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
    endtask

    task automatic test_alu();
        send(F_ADD, 32'hFFFF_FFFF, 32'd1, 5'd0);
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL add_latency: out_valid=%b, required 1", out_valid); end
        checks++; if (dataOut !== 32'd0)    begin errors++; $display("FAIL add_wrap: got %h, required 0", dataOut); end
        checks++; if (zero !== 1'b1)        begin errors++; $display("FAIL add_zero: got %b, required 1", zero); end
        send(F_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        checks++; if (dataOut !== 32'd1)    begin errors++; $display("FAIL slt_neg: got %h, required 1", dataOut); end
        send(F_SRL, 32'd0, 32'h8000_0000, 5'd31);
        checks++; if (dataOut !== 32'd1)    begin errors++; $display("FAIL srl_31: got %h, required 1", dataOut); end
        send(F_SRA, 32'd0, 32'h8000_0000, 5'd31);
        checks++; if (dataOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra_31: got %h, required ffffffff", dataOut); end
        send(6'd63, 32'd5, 32'd6, 5'd0);
        checks++; if (illegal !== 1'b1)     begin errors++; $display("FAIL illegal_funct: got %b, required 1", illegal); end
        drain();
    endtask

    task automatic test_multu();
        int n;
        send(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 32)              begin errors++; $display("FAIL mul_busy_cycles: got %0d, required 32", n); end
        checks++; if (out_valid !== 1'b1)   begin errors++; $display("FAIL mul_done_valid: got %b, required 1", out_valid); end
        send(F_MFHI, 32'd0, 32'd0, 5'd0);
        checks++; if (dataOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mfhi_mul: got %h, required fffffffe", dataOut); end
        send(F_MFLO, 32'd0, 32'd0, 5'd0);
        checks++; if (dataOut !== 32'h0000_0001) begin errors++; $display("FAIL mflo_mul: got %h, required 00000001", dataOut); end
        drain();
    endtask

    task automatic test_divu();
        send(F_DIVU, 32'd100, 32'd7, 5'd0);
`ifndef ALU_MDU_DIVU_EN
        checks++; if (illegal !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL divu_disabled: got valid=%b illegal=%b, required 1 1", out_valid, illegal);
        end
`endif
        send(F_MFLO, 32'd0, 32'd0, 5'd0);
`ifdef ALU_MDU_DIVU_EN
        checks++; if (dataOut !== 32'd14) begin errors++; $display("FAIL div_quot: got %h, required 0000000e", dataOut); end
`else
        checks++; if (dataOut !== 32'd1)  begin errors++; $display("FAIL div_lo_kept: got %h, required 00000001", dataOut); end
`endif
        send(F_MFHI, 32'd0, 32'd0, 5'd0);
`ifdef ALU_MDU_DIVU_EN
        checks++; if (dataOut !== 32'd2)  begin errors++; $display("FAIL div_rem: got %h, required 00000002", dataOut); end
`else
        checks++; if (dataOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div_hi_kept: got %h, required fffffffe", dataOut); end
`endif
        send(F_DIVU, 32'd5, 32'd0, 5'd0);
        send(F_MFHI, 32'd0, 32'd0, 5'd0);
`ifdef ALU_MDU_DIVU_EN
        checks++; if (dataOut !== 32'd5)  begin errors++; $display("FAIL div0_hi: got %h, required 00000005", dataOut); end
`else
        checks++; if (dataOut !== 32'hFFFF_FFFE) begin errors++; $display("FAIL div0_hi_kept: got %h, required fffffffe", dataOut); end
`endif
        send(F_MFLO, 32'd0, 32'd0, 5'd0);
`ifdef ALU_MDU_DIVU_EN
        checks++; if (dataOut !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0_lo: got %h, required ffffffff", dataOut); end
`else
        checks++; if (dataOut !== 32'd1)  begin errors++; $display("FAIL div0_lo_kept: got %h, required 00000001", dataOut); end
`endif
        drain();
    endtask

    task automatic test_reset_mid_op();
        send(F_MULTU, 32'd12345, 32'd678, 5'd0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_hi = '0;
        m_lo = '0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL midrst_ready: got %b, required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b, required 0", out_valid); end
        send(F_MFLO, 32'd0, 32'd0, 5'd0);
        checks++; if (dataOut !== 32'd0)  begin errors++; $display("FAIL midrst_mflo: got %h, required 0", dataOut); end
        send(F_MFHI, 32'd0, 32'd0, 5'd0);
        checks++; if (dataOut !== 32'd0)  begin errors++; $display("FAIL midrst_mfhi: got %h, required 0", dataOut); end
        drain();
    endtask

    task automatic test_hold_during_busy();
        int n;
        send(F_DIVU, 32'd200, 32'd9, 5'd0);
        in_valid = 1'b1;
        funct = F_ADD;
        dataA = 32'h1234_5678;
        dataB = 32'h1111_1111;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_accept_cycle: divu out_valid=%b, required 1", out_valid); end
        @(posedge clk);
        exp_q.push_back({1'b0, 32'h2345_6789});
        #1;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || dataOut !== 32'h2345_6789) begin
            errors++; $display("FAIL hold_add_result: got valid=%b data=%h, required 1 23456789", out_valid, dataOut);
        end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_single_accept: out_valid=%b, required 0", out_valid); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [5:0] ftab[14];
        logic [W-1:0] a;
        logic [W-1:0] b;
        ftab = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL, F_SRL, F_SRA,
                 F_MFHI, F_MFLO, F_MULTU, F_DIVU, 6'd1, 6'd63};
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            send(ftab[$urandom_range(0, 13)], a, b, 5'($urandom_range(0, 31)));
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_multu();
        test_divu();
        test_reset_mid_op();
        test_hold_during_busy();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
